adder_share_ctrl: RTL and testbench
===================================

ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 4, datapath byte width at 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 req  input  4  bit i = requester i asks for an add; held high until its gnt bit pulses.
REQ-005 wide  input  4  bit i = requester i op is 16-bit (two passes); 0 = 8-bit (low byte only).
REQ-006 opa  input  64  packed operand A; requester i at [16i+15:16i].
REQ-007 opb  input  64  packed operand B; same packing as opa.
REQ-008 gnt  output  4  one-hot, single-cycle pulse: requester's operands captured this edge.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  single-cycle pulse: result, c_out, done_id valid.
REQ-011 done_id  output  2  index of requester whose result is presented.
REQ-012 result  output  16  sum; held between done pulses.
REQ-013 c_out  output  1  final carry of the operation; held between done pulses.

Function
REQ-014 The block SHALL contain exactly one EightBitFullAdder instance, time-shared between low and high passes; no other adder for operand data.
REQ-015 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-016 IDLE: if any req bit set, select winner by round-robin, pulse gnt for winner combinationally-registered in that cycle, latch opa/opb/wide/id of winner, go LOW; else stay IDLE, gnt=0.
REQ-017 Round-robin: search starts at (last_id+1) mod 4 and wraps; last_id updates to the winner on each grant.
REQ-018 LOW: adder inputs = latched A[7:0], B[7:0], c_in=0; store sum to result_low, carry to carry_reg; go HIGH if wide latched, else DONE.
REQ-019 HIGH: adder inputs = A[15:8], B[15:8], c_in=carry_reg; store sum to result_high, carry to carry_reg; go DONE.
REQ-020 DONE: done=1 for exactly one cycle with result, c_out, done_id updated; go IDLE.
REQ-021 Narrow op: result[15:8]=0x00, c_out = low-pass carry; opa/opb high bytes ignored.
REQ-022 Wide op: result = (A+B) mod 2^16, c_out = bit 16 of A+B.
REQ-023 Latency: gnt at cycle T -> done at T+2 (narrow) or T+3 (wide); next grant no earlier than T+3 / T+4.
REQ-024 req, wide, opa, opb SHALL be ignored outside IDLE; operand changes after gnt SHALL not affect the in-flight op.
REQ-025 A req deasserted before its gnt SHALL be treated as withdrawn; no state retained.
REQ-026 Simultaneous requests: exactly one gnt bit per grant cycle; losers keep req high and win later with no starvation (max wait 3 ops).
REQ-027 gnt, done SHALL never be high in the same cycle; gnt only in IDLE, done only in DONE.

Reset
REQ-028 On reset assertion, immediately: state=IDLE, gnt=0, busy=0, done=0, done_id=0, result=0x0000, c_out=0, last_id=3 (requester 0 wins first).
REQ-029 Reset mid-operation SHALL discard the in-flight op; no done pulse for it after release.
REQ-030 First grant possible on the first rising clk edge after reset deasserts.

Verification
REQ-031 Narrow: req=0001, wide=0, A0=0x00F0, B0=0x0020 -> gnt=0001 at T, done at T+2, result=0x0010, c_out=1, done_id=0.
REQ-032 Wide carry chain: req=0100, wide=0100, A2=0x01FF, B2=0x0001 -> done at T+3, result=0x0200, c_out=0; A2=0xFFFF, B2=0x0001 -> result=0x0000, c_out=1.
REQ-033 Arbitration: req=1111 held, all narrow -> gnt sequence 0001,0010,0100,1000,0001, grants 3 cycles apart, done_id 0,1,2,3,0.
REQ-034 Operand stability: change A1 on cycle after gnt=0010 -> result reflects originally captured value.
REQ-035 Reset mid-op: assert reset during HIGH of a wide op -> all outputs to reset values immediately, no done after release; req=0010 then -> gnt=0010 first.

Source files
------------

// File: rtl/adder_share_ctrl.sv
// Round-robin controller that time-shares one 8-bit adder among four requesters.
// 8-bit ops take a single low pass; 16-bit ops add a high pass chained through the carry.

module EightBitFullAdder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, c_i};
endmodule

module adder_share_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  wide,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [15:0] result,
  output logic        c_out
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e      state_q;
  logic [15:0] a_q, b_q;
  logic        wide_q;
  logic [1:0]  id_q, last_id_q;
  logic        carry_q;
  logic [7:0]  res_lo_q, res_hi_q;
  logic [3:0]  gnt_q;
  logic        done_q;
  logic [1:0]  done_id_q;
  logic [15:0] result_q;
  logic        c_out_q;

  logic        win_valid_d;
  logic [1:0]  win_id_d, cand_id_d;
  logic [7:0]  add_a_d, add_b_d, add_s_d;
  logic        add_c_d, add_co_d;

  // Round-robin: scan from the requester after the last winner, wrapping.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    win_valid_d = 1'b0;
    win_id_d    = 2'd0;
    cand_id_d   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_id_d = last_id_q + 2'(k + 1);
      if (!win_valid_d && req[cand_id_d]) begin
        win_valid_d = 1'b1;
        win_id_d    = cand_id_d;
      end
    end
  end

  always_comb begin
    add_a_d = a_q[7:0];
    add_b_d = b_q[7:0];
    add_c_d = 1'b0;
    if (state_q == HIGH) begin
      add_a_d = a_q[15:8];
      add_b_d = b_q[15:8];
      add_c_d = carry_q;
    end
  end

  EightBitFullAdder u_adder (
    .a_i (add_a_d),
    .b_i (add_b_d),
    .c_i (add_c_d),
    .s_o (add_s_d),
    .c_o (add_co_d)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers, operand latches included, are reset so no stale op survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      wide_q    <= 1'b0;
      id_q      <= '0;
      last_id_q <= 2'd3;
      carry_q   <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
      c_out_q   <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            gnt_q     <= 4'b0001 << win_id_d;
            a_q       <= opa[16*win_id_d +: 16];
            b_q       <= opb[16*win_id_d +: 16];
            wide_q    <= wide[win_id_d];
            id_q      <= win_id_d;
            last_id_q <= win_id_d;
            state_q   <= LOW;
          end
        end
        LOW: begin
          res_lo_q <= add_s_d;
          carry_q  <= add_co_d;
          state_q  <= wide_q ? HIGH : DONE;
        end
        HIGH: begin
          res_hi_q <= add_s_d;
          carry_q  <= add_co_d;
          state_q  <= DONE;
        end
        DONE: begin
          done_q    <= 1'b1;
          done_id_q <= id_q;
          result_q  <= wide_q ? {res_hi_q, res_lo_q} : {8'h00, res_lo_q};
          c_out_q   <= carry_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign c_out   = c_out_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: reset, narrow/wide ops, arbitration,
// operand capture, withdrawn requests and reset during an operation.

module tb_adder_share_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  wide;
  logic [63:0] opa;
  logic [63:0] opb;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] result;
  logic        c_out;

  int total = 0;
  int bad   = 0;

  adder_share_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wide    (wide),
    .opa     (opa),
    .opb     (opb),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .c_out   (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; req = '0; wide = '0; opa = '0; opb = '0;
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (done_id !== 2'd0) begin bad++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out: got %b want 0", c_out); end
    reset = 1'b0;
  endtask

  // One isolated op from requester id; caller is at a negedge with the block idle.
  task automatic run_op(input string name, input logic [1:0] id, input logic is_wide,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_r, input logic exp_c);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << id;
    req = '0; wide = '0;
    opa[16*id +: 16] = a;
    opb[16*id +: 16] = b;
    wide[id] = is_wide;
    req[id]  = 1'b1;
    @(negedge clk);
    total++; if (gnt !== exp_g) begin bad++; $display("FAIL %s_gnt: got %b want %b", name, gnt, exp_g); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    req = '0;
    for (int c = 0; c < (is_wide ? 2 : 1); c++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || gnt !== 4'b0000) begin
        bad++; $display("FAIL %s_early: done=%b gnt=%b want done=0 gnt=0000", name, done, gnt);
      end
    end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done: got %b want 1", name, done); end
    total++; if (result !== exp_r) begin bad++; $display("FAIL %s_result: got %h want %h", name, result, exp_r); end
    total++; if (c_out !== exp_c) begin bad++; $display("FAIL %s_c_out: got %b want %b", name, c_out, exp_c); end
    total++; if (done_id !== id) begin bad++; $display("FAIL %s_done_id: got %0d want %0d", name, done_id, id); end
    @(negedge clk);
    total++; if (done !== 1'b0 || result !== exp_r) begin
      bad++; $display("FAIL %s_hold: done=%b result=%h want done=0 result=%h", name, done, result, exp_r);
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] exp_r;
    logic [1:0]  exp_id;
    logic [3:0]  exp_g;
    wide = '0;
    for (int i = 0; i < 4; i++) begin
      opa[16*i +: 16] = 16'h0010 * 16'(i + 1);
      opb[16*i +: 16] = 16'h0005;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp_g  = 4'b0001 << exp_id;
      exp_r  = 16'h0010 * 16'(exp_id + 1) + 16'h0005;
      @(negedge clk);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL arb_gnt%0d: got %b want %b", k, gnt, exp_g); end
      if (k == 4) req = '0;
      @(negedge clk);
      total++; if (gnt !== 4'b0000 || done !== 1'b0) begin
        bad++; $display("FAIL arb_gap%0d: gnt=%b done=%b want 0000/0", k, gnt, done);
      end
      @(negedge clk);
      total++; if (done !== 1'b1 || gnt !== 4'b0000) begin
        bad++; $display("FAIL arb_done%0d: done=%b gnt=%b want 1/0000", k, done, gnt);
      end
      total++; if (done_id !== exp_id || result !== exp_r) begin
        bad++; $display("FAIL arb_res%0d: id=%0d result=%h want id=%0d result=%h", k, done_id, result, exp_id, exp_r);
      end
    end
  endtask

  task automatic test_narrow();
    run_op("narrow", 2'd0, 1'b0, 16'h00F0, 16'h0020, 16'h0010, 1'b1);
    run_op("narrow_hi_ignored", 2'd3, 1'b0, 16'hAB7F, 16'hCD01, 16'h0080, 1'b0);
  endtask

  task automatic test_wide();
    run_op("wide_chain", 2'd2, 1'b1, 16'h01FF, 16'h0001, 16'h0200, 1'b0);
    run_op("wide_wrap", 2'd2, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    run_op("wide_plain", 2'd1, 1'b1, 16'h1234, 16'h4321, 16'h5555, 1'b0);
  endtask

  task automatic test_operand_stability();
    req = '0; wide = '0;
    opa[31:16] = 16'h0011;
    opb[31:16] = 16'h0022;
    req = 4'b0010;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stab_gnt: got %b want 0010", gnt); end
    opa[31:16] = 16'h00FF;
    opb[31:16] = 16'h00FF;
    wide = 4'b0010;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1 || result !== 16'h0033 || c_out !== 1'b0) begin
      bad++; $display("FAIL stab_result: done=%b result=%h c=%b want 1/0033/0", done, result, c_out);
    end
    wide = '0;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    req = '0; wide = '0;
    opa[15:0] = 16'h0001; opb[15:0] = 16'h0001;
    req = 4'b0001;
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_gnt: got %b want 0001", gnt); end
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    total++; if (done !== 1'b1 || result !== 16'h0002) begin
      bad++; $display("FAIL wd_done: done=%b result=%h want 1/0002", done, result);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
        bad++; $display("FAIL wd_idle%0d: gnt=%b busy=%b want 0000/0", c, gnt, busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    req = '0; wide = 4'b0100;
    opa[47:32] = 16'h01FF; opb[47:32] = 16'h0001;
    req = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_op_gnt: got %b want 0100", gnt); end
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ctrl: busy=%b gnt=%b done=%b want 0/0000/0", busy, gnt, done);
    end
    total++; if (result !== 16'h0000 || c_out !== 1'b0 || done_id !== 2'd0) begin
      bad++; $display("FAIL rst_mid_data: result=%h c=%b id=%0d want 0000/0/0", result, c_out, done_id);
    end
    @(negedge clk);
    reset = 1'b0;
    wide = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_no_done%0d: done=%b busy=%b want 0/0", c, done, busy);
      end
    end
    opa[31:16] = 16'h0003; opb[31:16] = 16'h0004;
    req = 4'b0010;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_next_gnt: got %b want 0010", gnt); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1 || result !== 16'h0007 || done_id !== 2'd1) begin
      bad++; $display("FAIL rst_next_done: done=%b result=%h id=%0d want 1/0007/1", done, result, done_id);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_narrow();
    test_wide();
    test_operand_stability();
    test_withdraw();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
